// File: rtl/lsu_types_pkg.sv
// -----------------------------------------------------------------------------
// lsu_types_pkg
// Types and sizes shared by the LSU, the dcache and the cacheline adapter.
//   CACHELINE_BITS  : width of one dcache line
//   BURST_BEAT_BITS : width of one beat on the banked burst memory
//   BURST_BEATS     : beats needed to move one line
//   cl_adapter_state_t : control states of the cacheline adapter
// -----------------------------------------------------------------------------
package lsu_types_pkg;

    localparam int CACHELINE_BITS  = 256;
    localparam int BURST_BEAT_BITS = 64;
    localparam int BURST_BEATS     = CACHELINE_BITS / BURST_BEAT_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        DONE    = 3'd4
    } cl_adapter_state_t;

endpackage : lsu_types_pkg

// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
// Splits one dcache line request into a burst of beats on the banked burst
// memory and reassembles returned beats into a line. One line transaction is
// in flight at a time.
//
// Ports
//   clk, rst            : clock; synchronous active-low reset
//   ufp_addr            : line address from the dcache (offset bits ignored)
//   ufp_read/ufp_write  : line request (read has priority when both are set)
//   ufp_wdata           : line to write
//   ufp_rdata           : last assembled read line
//   ufp_resp            : one-cycle completion pulse
//   bmem_addr           : line-aligned burst address
//   bmem_read           : burst read command, held until bmem_ready
//   bmem_write          : write beat valid, beat advances on bmem_ready
//   bmem_wdata          : current write beat (lowest beat first)
//   bmem_ready          : memory accepts command or beat this cycle
//   bmem_raddr          : line address tagging a returned beat
//   bmem_rdata          : returned beat
//   bmem_rvalid         : returned beat valid
//   err                 : sticky protocol-error flag
// -----------------------------------------------------------------------------
module cacheline_adapter
    import lsu_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = CACHELINE_BITS,
    parameter int BEAT_WIDTH = BURST_BEAT_BITS
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] ufp_addr,
    input  logic                  ufp_read,
    input  logic                  ufp_write,
    input  logic [LINE_WIDTH-1:0] ufp_wdata,
    output logic [LINE_WIDTH-1:0] ufp_rdata,
    output logic                  ufp_resp,

    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid,

    output logic                  err
);

    localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    cl_adapter_state_t     state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] aligned_addr_s;
    logic                  beat_hit_s;

    // Line-align the incoming address by forcing the byte-offset bits to zero
    assign aligned_addr_s = {ufp_addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};

    // Next-state and datapath update for the transaction controller
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        line_d     = line_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        // A returned beat only counts while collecting a read and only when
        // it is tagged with our own line; anything else is a protocol error.
        beat_hit_s = (state_q == RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);

        if (bmem_rvalid && !beat_hit_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                if (ufp_read) begin
                    addr_d  = aligned_addr_s;
                    state_d = RD_REQ;
                end else if (ufp_write) begin
                    addr_d     = aligned_addr_s;
                    wdata_d    = ufp_wdata;
                    beat_cnt_d = '0;
                    state_d    = WR_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    beat_cnt_d = '0;
                    state_d    = RD_DATA;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_DATA: begin
                if (beat_hit_s) begin
                    line_d[int'(beat_cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_DATA;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_DATA: begin
                // A stall leaves the counter, and therefore the beat, unchanged
                if (bmem_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            DONE: begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Output decode from registered state only; nothing passes through from ufp_*
    always_comb begin
        bmem_read  = (state_q == RD_REQ);
        bmem_write = (state_q == WR_DATA);
        ufp_resp   = (state_q == DONE);
        ufp_rdata  = line_q;
        err        = err_q;
        if (bmem_read || bmem_write) begin
            bmem_addr = addr_q;
        end else begin
            bmem_addr = '0;
        end
        if (bmem_write) begin
            bmem_wdata = wdata_q[int'(beat_cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
        end else begin
            bmem_wdata = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            line_q     <= line_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule : cacheline_adapter

// File: tb/tb_cacheline_adapter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adapter
// Directed bench for cacheline_adapter: the memory side is driven cycle by
// cycle from one initial block, and every expected value is written out by
// hand. Passive monitors count completion pulses and record accepted beats.
// -----------------------------------------------------------------------------
module tb_cacheline_adapter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ufp_addr;
    logic          ufp_read;
    logic          ufp_write;
    logic [LW-1:0] ufp_wdata;
    logic [LW-1:0] ufp_rdata;
    logic          ufp_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic          bmem_ready;
    logic [AW-1:0] bmem_raddr;
    logic [BW-1:0] bmem_rdata;
    logic          bmem_rvalid;
    logic          err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor state, written only by the monitor process
    int            resp_pulses  = 0;
    int            write_cycles = 0;
    int            wr_n         = 0;
    logic [BW-1:0] wr_seen [0:31];

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .ufp_addr   (ufp_addr),
        .ufp_read   (ufp_read),
        .ufp_write  (ufp_write),
        .ufp_wdata  (ufp_wdata),
        .ufp_rdata  (ufp_rdata),
        .ufp_resp   (ufp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid),
        .err        (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count completion pulses, write cycles and record beats the memory accepts
    always @(posedge clk) begin
        if (ufp_resp === 1'b1) resp_pulses <= resp_pulses + 1;
        if (bmem_write === 1'b1) write_cycles <= write_cycles + 1;
        if (bmem_write === 1'b1 && bmem_ready === 1'b1 && wr_n < 32) begin
            wr_seen[wr_n] <= bmem_wdata;
            wr_n          <= wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one tagged beat for a single cycle
    task automatic send_beat(input logic [AW-1:0] tag_addr, input logic [BW-1:0] data);
        bmem_rvalid = 1'b1;
        bmem_raddr  = tag_addr;
        bmem_rdata  = data;
        tick();
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    logic [BW-1:0] beats [0:3];
    logic [BW-1:0] wbeats [0:3];
    bit            pat [0:5];
    int            p0;
    int            n0;
    int            w0;
    int            idx;
    int            k;

    initial begin
        rst         = 1'b0;
        ufp_addr    = '0;
        ufp_read    = 1'b0;
        ufp_write   = 1'b0;
        ufp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk1("rst_bmem_read", bmem_read, 1'b0);
        chk1("rst_bmem_write", bmem_write, 1'b0);
        chk1("rst_ufp_resp", ufp_resp, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk_addr("rst_bmem_addr", bmem_addr, 32'h0000_0000);
        chk_line("rst_ufp_rdata", ufp_rdata, '0);
        rst = 1'b1;
        tick();

        // ---- read with a 3-cycle ready stall ----
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        p0 = resp_pulses;
        ufp_addr = 32'h1000_0024;
        ufp_read = 1'b1;
        tick();
        chk1("t1_rdreq", bmem_read, 1'b1);
        chk_addr("t1_bmem_addr", bmem_addr, 32'h1000_0020);
        chk1("t1_no_write", bmem_write, 1'b0);
        repeat (3) tick();
        chk1("t1_rdreq_held", bmem_read, 1'b1);
        bmem_ready = 1'b1;
        tick();
        bmem_ready = 1'b0;
        chk1("t1_rdreq_dropped", bmem_read, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk1("t1_resp_early", ufp_resp, 1'b0);
            send_beat(32'h1000_0020, beats[i]);
        end
        chk1("t1_resp", ufp_resp, 1'b1);
        chk_line("t1_rdata", ufp_rdata, {beats[3], beats[2], beats[1], beats[0]});
        ufp_read = 1'b0;
        tick();
        chk1("t1_resp_oneshot", ufp_resp, 1'b0);
        chk_line("t1_rdata_stable", ufp_rdata, {beats[3], beats[2], beats[1], beats[0]});
        chk_int("t1_resp_count", resp_pulses - p0, 1);

        // ---- write with ready pattern 1,0,1,1,0,1 ----
        wbeats[0] = 64'hAAAA_0000_AAAA_0000;
        wbeats[1] = 64'hBBBB_1111_BBBB_1111;
        wbeats[2] = 64'hCCCC_2222_CCCC_2222;
        wbeats[3] = 64'hDDDD_3333_DDDD_3333;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        n0 = wr_n;
        ufp_addr  = 32'h0000_105F;
        ufp_wdata = {wbeats[3], wbeats[2], wbeats[1], wbeats[0]};
        ufp_write = 1'b1;
        tick();
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            bmem_ready = pat[i];
            chk1("t2_wvalid", bmem_write, 1'b1);
            chk_addr("t2_bmem_addr", bmem_addr, 32'h0000_1040);
            chk_beat("t2_wdata", bmem_wdata, wbeats[idx]);
            chk1("t2_resp_early", ufp_resp, 1'b0);
            tick();
            if (pat[i]) idx++;
        end
        bmem_ready = 1'b0;
        chk1("t2_resp", ufp_resp, 1'b1);
        chk1("t2_write_dropped", bmem_write, 1'b0);
        chk_int("t2_beats_accepted", wr_n - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk_beat("t2_mem_order", wr_seen[n0 + i], wbeats[i]);
        end
        ufp_write = 1'b0;
        tick();
        chk1("t2_resp_oneshot", ufp_resp, 1'b0);

        // ---- gapped read beats on cycles 0,2,3,7 ----
        beats[0] = 64'h0123_4567_89AB_CDEF;
        beats[1] = 64'hFEDC_BA98_7654_3210;
        beats[2] = 64'h0F0F_0F0F_F0F0_F0F0;
        beats[3] = 64'h5A5A_A5A5_3C3C_C3C3;
        ufp_addr   = 32'h0000_0340;
        ufp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        tick();
        bmem_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 2 || c == 3 || c == 7) begin
                if (c == 7) chk1("t3_resp_early", ufp_resp, 1'b0);
                send_beat(32'h0000_0340, beats[k]);
                k++;
            end else begin
                tick();
            end
        end
        chk1("t3_resp", ufp_resp, 1'b1);
        chk_line("t3_rdata", ufp_rdata, {beats[3], beats[2], beats[1], beats[0]});
        ufp_read = 1'b0;
        tick();

        // ---- stray beat while idle sets err; reset clears it ----
        chk1("t4_err_before", err, 1'b0);
        send_beat(32'h0000_0000, 64'h0BAD_0BAD_0BAD_0BAD);
        chk1("t4_err_idle_stray", err, 1'b1);
        rst = 1'b0;
        tick();
        chk1("t4_err_cleared", err, 1'b0);
        rst = 1'b1;
        tick();

        // ---- mis-tagged beat during a read is discarded and flagged ----
        beats[0] = 64'h5555_5555_5555_5555;
        beats[1] = 64'h6666_6666_6666_6666;
        beats[2] = 64'h7777_7777_7777_7777;
        beats[3] = 64'h8888_8888_8888_8888;
        ufp_addr   = 32'h1000_0020;
        ufp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        tick();
        bmem_ready = 1'b0;
        send_beat(32'h1000_0020, beats[0]);
        chk1("t4_err_good_beat", err, 1'b0);
        send_beat(32'h2000_0000, 64'hDEAD_BEEF_DEAD_BEEF);
        chk1("t4_err_bad_tag", err, 1'b1);
        chk1("t4_no_resp_yet", ufp_resp, 1'b0);
        for (int i = 1; i < 4; i++) send_beat(32'h1000_0020, beats[i]);
        chk1("t4_resp", ufp_resp, 1'b1);
        chk_line("t4_rdata", ufp_rdata, {beats[3], beats[2], beats[1], beats[0]});
        ufp_read = 1'b0;
        tick();
        chk1("t4_err_sticky", err, 1'b1);

        // ---- read and write together: read wins ----
        w0 = write_cycles;
        beats[0] = 64'h9999_0000_0000_0001;
        beats[1] = 64'h9999_0000_0000_0002;
        beats[2] = 64'h9999_0000_0000_0003;
        beats[3] = 64'h9999_0000_0000_0004;
        ufp_addr   = 32'h0000_0080;
        ufp_wdata  = {4{64'hEEEE_EEEE_EEEE_EEEE}};
        ufp_read   = 1'b1;
        ufp_write  = 1'b1;
        bmem_ready = 1'b1;
        tick();
        chk1("t5_rdreq", bmem_read, 1'b1);
        chk1("t5_no_write", bmem_write, 1'b0);
        chk_addr("t5_bmem_addr", bmem_addr, 32'h0000_0080);
        tick();
        bmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h0000_0080, beats[i]);
        chk1("t5_resp", ufp_resp, 1'b1);
        chk_line("t5_rdata", ufp_rdata, {beats[3], beats[2], beats[1], beats[0]});
        ufp_read  = 1'b0;
        ufp_write = 1'b0;
        tick();
        chk_int("t5_write_cycles", write_cycles - w0, 0);

        // ---- reset in the middle of a write ----
        wbeats[0] = 64'h0000_0000_0000_00A0;
        wbeats[1] = 64'h0000_0000_0000_00A1;
        wbeats[2] = 64'h0000_0000_0000_00A2;
        wbeats[3] = 64'h0000_0000_0000_00A3;
        ufp_addr   = 32'h0000_0200;
        ufp_wdata  = {wbeats[3], wbeats[2], wbeats[1], wbeats[0]};
        ufp_write  = 1'b1;
        bmem_ready = 1'b1;
        tick();
        chk1("t6_write_active", bmem_write, 1'b1);
        tick();
        tick();
        chk_beat("t6_wdata_beat2", bmem_wdata, wbeats[2]);
        rst        = 1'b0;
        ufp_write  = 1'b0;
        bmem_ready = 1'b0;
        tick();
        chk1("t6_write_dropped", bmem_write, 1'b0);
        chk1("t6_err_clear", err, 1'b0);
        chk1("t6_resp_clear", ufp_resp, 1'b0);
        chk_addr("t6_addr_clear", bmem_addr, 32'h0000_0000);
        chk_line("t6_rdata_clear", ufp_rdata, '0);
        rst = 1'b1;

        // A read right after reset is accepted at once, proving the FSM is idle
        beats[0] = 64'hC0DE_0000_0000_0040;
        beats[1] = 64'hC0DE_0000_0000_0041;
        beats[2] = 64'hC0DE_0000_0000_0042;
        beats[3] = 64'hC0DE_0000_0000_0043;
        ufp_addr   = 32'h0000_0040;
        ufp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        chk1("t6_rdreq", bmem_read, 1'b1);
        chk_addr("t6_bmem_addr", bmem_addr, 32'h0000_0040);
        tick();
        bmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk1("t6_resp_early", ufp_resp, 1'b0);
            send_beat(32'h0000_0040, beats[i]);
        end
        chk1("t6_resp", ufp_resp, 1'b1);
        chk_line("t6_rdata", ufp_rdata, {beats[3], beats[2], beats[1], beats[0]});
        chk1("t6_err_still_clear", err, 1'b0);
        ufp_read = 1'b0;
        tick();
        chk1("t6_resp_oneshot", ufp_resp, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_cacheline_adapter

// File: doc/cacheline_adapter.md
# cacheline_adapter

Converts the dcache's 256-bit cacheline requests into 4-beat × 64-bit bursts on the banked burst memory, and reassembles returned beats into a line. It sits directly downstream of the LSU's dcache. It is the slave on the dcache's cacheline port and the master on the memory burst port. It holds one outstanding line transaction at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cacheline width in bits
- BEAT_WIDTH, 64, burst beat width; beats per line = LINE_WIDTH/BEAT_WIDTH = 4

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-low
- ufp_addr  in  ADDR_WIDTH  line address; bits [4:0] are ignored and treated as 0
- ufp_read  in  1  line read request
- ufp_write  in  1  line write request
- ufp_wdata  in  LINE_WIDTH  line to write
- ufp_rdata  out  LINE_WIDTH  assembled read line
- ufp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  ADDR_WIDTH  burst line address, 32-byte aligned
- bmem_read  out  1  burst read command
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  BEAT_WIDTH  write beat
- bmem_ready  in  1  memory accepts the command or beat this cycle
- bmem_raddr  in  ADDR_WIDTH  line address tagging the returned beat
- bmem_rdata  in  BEAT_WIDTH  returned beat
- bmem_rvalid  in  1  returned beat valid
- err  out  1  sticky protocol-error flag

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, DONE.
- IDLE:
  - ufp_read → latch the aligned address into addr_q → RD_REQ.
  - Otherwise, ufp_write → latch the aligned address and ufp_wdata → WR_DATA.
  - If read and write are asserted together, the read wins and the write is ignored.
- RD_REQ: bmem_read=1 and bmem_addr=addr_q, held until bmem_ready=1. That cycle, beat_cnt is cleared → RD_DATA.
- RD_DATA:
  - Each bmem_rvalid with bmem_raddr==addr_q stores bmem_rdata into line_q[64·beat_cnt +: 64] and increments beat_cnt.
  - The beat at beat_cnt==3 → DONE.
  - Beats may arrive non-consecutively.
- WR_DATA:
  - bmem_write=1, bmem_addr=addr_q, bmem_wdata=wdata_q[64·beat_cnt +: 64].
  - beat_cnt advances only on cycles with bmem_ready=1.
  - The accepted beat 3 → DONE.
- DONE: ufp_resp=1 for exactly one cycle → IDLE. ufp_rdata=line_q, and it stays stable until the next read's first beat lands.
- Beat order: beat k maps to bits [64k+63:64k], lowest beat first, in both directions.
- The upstream side holds its request until ufp_resp and deasserts it in the cycle after ufp_resp. Requests seen outside IDLE are ignored.
- err is set and stays set until reset when either of these occurs:
  - bmem_rvalid outside RD_DATA;
  - bmem_rvalid in RD_DATA with bmem_raddr≠addr_q. The beat is discarded and beat_cnt does not advance.

## Timing
- Reset (rst=0 at an edge) forces IDLE with beat_cnt=0, err=0, line_q=0, and all outputs 0. This applies mid-transaction too: the burst is abandoned and the command drops on the next cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from ufp_* to bmem_*.
- Read latency, request edge to ufp_resp: 1 (IDLE→RD_REQ) + RD_REQ wait + 4 beats + 1 (DONE). The minimum is 7 cycles, with bmem_ready=1 immediately and rvalid on 4 consecutive cycles starting the cycle after acceptance.
- Write latency minimum: 1 + 4 beats + 1 = 6 cycles, with bmem_ready=1 throughout.
- A bmem_ready stall holds bmem_wdata and beat_cnt unchanged.
- Back-to-back requests: the earliest new acceptance is the cycle after DONE, so there is one idle cycle between transactions.

## Structure
- Shared package (cpu_params or lsu_types), which dcache and lsu also use:
  - CACHELINE_BITS=256, BURST_BEAT_BITS=64, BURST_BEATS=4;
  - an enum cl_adapter_state_t {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE}.
- Single flat module, no sub-modules. The 2-bit beat counter and the line/beat mux are small enough to stay inline.

## Test plan
- Read with a 3-cycle ready stall: ufp_read @0x1000_0024 → bmem_addr=0x1000_0020. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → ufp_rdata = {0x44..,0x33..,0x22..,0x11..}. ufp_resp occurs exactly once, 3 cycles later than the minimum.
- Write with ready toggling 1,0,1,1,0,1: wdata = beats A,B,C,D → the memory sees A,B,C,D in order, each held across its stall. ufp_resp comes 1 cycle after D is accepted.
- Gapped read beats: rvalid on cycles 0,2,3,7 → the line is correct, and ufp_resp comes one cycle after the cycle-7 beat.
- Protocol error: a stray rvalid in IDLE, then a read beat tagged 0x2000_0000 during a read of 0x1000_0020 → err=1, the stray beat is discarded, and the read completes with the correct data.
- Simultaneous read+write in IDLE → a read burst is issued and bmem_write never asserts.
- Reset mid-write after beat 1 → the next cycle has bmem_write=0, state IDLE, err=0. A following read at 0x40 completes normally.
